// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: EX/MEM -> data memory req/ack handshake -> MEM/WB register.
// Optional macro ALIGN_CHECK_EN adds misaligned-access detection and the misalign_o port.
module mem_access_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [4:0]    in_ctrl,
    input  logic [DW-1:0] in_alu,
    input  logic [DW-1:0] in_wdata,
    input  logic [RW-1:0] in_rd,
    output logic          stall_o,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          wb_valid,
    output logic [2:0]    wb_ctrl,
    output logic [DW-1:0] wb_rdata,
    output logic [DW-1:0] wb_alu,
    output logic [RW-1:0] wb_rd
`ifdef ALIGN_CHECK_EN
    ,
    output logic          misalign_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wb_valid_q, wb_valid_d;
    logic [2:0]    wb_ctrl_q, wb_ctrl_d;
    logic [DW-1:0] wb_rdata_q, wb_rdata_d;
    logic [DW-1:0] wb_alu_q, wb_alu_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic          is_mem, misalign, memop;

    assign is_mem = in_valid & (in_ctrl[2] | in_ctrl[3]);
`ifdef ALIGN_CHECK_EN
    logic mis_q, mis_d;
    assign misalign   = is_mem & (in_alu[1:0] != 2'b00);
    assign misalign_o = mis_q;
`else
    assign misalign = 1'b0;
`endif
    // Misaligned accesses bypass the memory entirely and retire as plain pass-through.
    assign memop   = is_mem & ~misalign;
    assign stall_o = memop & (state_q != RESP);

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign wb_rdata  = wb_rdata_q;
    assign wb_alu    = wb_alu_q;
    assign wb_rd     = wb_rd_q;

    // State and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_ctrl_q  <= 3'b000;
            wb_rdata_q <= '0;
            wb_alu_q   <= '0;
            wb_rd_q    <= '0;
`ifdef ALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wb_valid_q <= wb_valid_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_rd_q    <= wb_rd_d;
`ifdef ALIGN_CHECK_EN
            mis_q      <= mis_d;
`endif
        end
    end

    // Next-state, memory-side latches and MEM/WB next values
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wb_valid_d = 1'b0;
        wb_ctrl_d  = 3'b000;
        wb_rdata_d = wb_rdata_q;
        wb_alu_d   = wb_alu_q;
        wb_rd_d    = wb_rd_q;
`ifdef ALIGN_CHECK_EN
        mis_d      = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (memop) begin
                    state_d = ACCESS;
                    we_d    = ~in_ctrl[2];
                    addr_d  = {in_alu[DW-1:2], 2'b00};
                    wdata_d = in_wdata;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d    = IDLE;
                wb_rdata_d = rdata_q;
            end
            default: state_d = IDLE;
        endcase

        req_d = (state_d == ACCESS);

        if (!stall_o) begin
            wb_valid_d = in_valid;
            wb_ctrl_d  = in_valid ? {in_ctrl[4], in_ctrl[1], in_ctrl[0] & ~misalign} : 3'b000;
            wb_alu_d   = in_alu;
            wb_rd_d    = in_rd;
`ifdef ALIGN_CHECK_EN
            mis_d      = misalign;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB entries queued at issue, checked on retire.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_ctrl;
    logic [31:0] in_alu;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        stall_o;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [2:0]  wb_ctrl;
    logic [31:0] wb_rdata;
    logic [31:0] wb_alu;
    logic [4:0]  wb_rd;
`ifdef ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    mem_access_stage #(.DW(32), .RW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_alu    (in_alu),
        .in_wdata  (in_wdata),
        .in_rd     (in_rd),
        .stall_o   (stall_o),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wb_valid  (wb_valid),
        .wb_ctrl   (wb_ctrl),
        .wb_rdata  (wb_rdata),
        .wb_alu    (wb_alu),
        .wb_rd     (wb_rd)
`ifdef ALIGN_CHECK_EN
        ,
        .misalign_o(misalign_o)
`endif
    );

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;
    exp_t mon_e;
    logic mon_mis;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retirement monitor: pops the scoreboard on every valid MEM/WB entry
    always @(negedge clk) begin
        if (mon_en) begin
            mon_mis = 1'b0;
            if (wb_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_unexpected: got wb_valid=1 alu=%h rd=%0d, required no entry", wb_alu, wb_rd);
                end else begin
                    mon_e   = sb.pop_front();
                    mon_mis = mon_e.mis;
                    if ({wb_ctrl, wb_alu, wb_rd} !== {mon_e.ctrl, mon_e.alu, mon_e.rd}) begin
                        n_fail++;
                        $display("FAIL wb_entry: got ctrl=%b alu=%h rd=%0d, required ctrl=%b alu=%h rd=%0d",
                                 wb_ctrl, wb_alu, wb_rd, mon_e.ctrl, mon_e.alu, mon_e.rd);
                    end
                    if (mon_e.chk_rdata) begin
                        n_checks++;
                        if (wb_rdata !== mon_e.rdata) begin
                            n_fail++;
                            $display("FAIL wb_rdata: got %h, required %h", wb_rdata, mon_e.rdata);
                        end
                    end
                end
            end else begin
                n_checks++;
                if (wb_ctrl !== 3'b000) begin
                    n_fail++;
                    $display("FAIL bubble_ctrl: got %b, required 000", wb_ctrl);
                end
            end
`ifdef ALIGN_CHECK_EN
            n_checks++;
            if (misalign_o !== mon_mis) begin
                n_fail++;
                $display("FAIL misalign_o: got %b, required %b", misalign_o, mon_mis);
            end
`endif
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_ctrl  = 5'b0;
            mem_ack  = 1'b0;
        end
    endtask

    // Issue one instruction, act as memory (ack on the ack_n-th request cycle), check handshake and latency
    task automatic drive(input logic [4:0] ctrl, input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [4:0] rd, input int ack_n, input logic [31:0] rdata);
        exp_t e;
        logic is_mem, mis, exp_we;
        int   cyc, nreq, exp_lat, exp_req;
        is_mem = ctrl[2] | ctrl[3];
        mis    = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis = is_mem && (alu[1:0] != 2'b00);
`endif
        exp_we      = ~ctrl[2];
        e.ctrl      = {ctrl[4], ctrl[1], ctrl[0] & ~mis};
        e.alu       = alu;
        e.rd        = rd;
        e.chk_rdata = is_mem & ctrl[2] & ~mis;
        e.rdata     = rdata;
        e.mis       = mis;
        sb.push_back(e);
        exp_req = (is_mem && !mis) ? ack_n : 0;
        exp_lat = (is_mem && !mis) ? 2 + ack_n : 1;

        @(negedge clk);
        in_valid  = 1'b1;
        in_ctrl   = ctrl;
        in_alu    = alu;
        in_wdata  = wdata;
        in_rd     = rd;
        mem_ack   = 1'b0;
        mem_rdata = rdata;
        #1;
        n_checks++;
        if (stall_o !== (is_mem && !mis)) begin
            n_fail++;
            $display("FAIL stall_first: got %b, required %b (alu=%h)", stall_o, is_mem && !mis, alu);
        end
        cyc  = 0;
        nreq = 0;
        while (stall_o === 1'b1 && cyc < 64) begin
            if (mem_req === 1'b1) begin
                nreq++;
                n_checks++;
                if (mem_addr !== {alu[31:2], 2'b00} || mem_we !== exp_we || (exp_we && mem_wdata !== wdata)) begin
                    n_fail++;
                    $display("FAIL mem_bus: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                             mem_addr, mem_we, mem_wdata, {alu[31:2], 2'b00}, exp_we, wdata);
                end
                if (nreq == ack_n) mem_ack = 1'b1;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
        end
        n_checks++;
        if (cyc >= 64) begin
            n_fail++;
            $display("FAIL stall_timeout: stall_o still %b after %0d cycles, required release", stall_o, cyc);
        end else if (cyc + 1 != exp_lat || nreq != exp_req) begin
            n_fail++;
            $display("FAIL latency: got lat=%0d req_cycles=%0d, required lat=%0d req_cycles=%0d",
                     cyc + 1, nreq, exp_lat, exp_req);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'b0) begin
            n_fail++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h, required all 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({wb_valid, wb_ctrl, wb_rdata, wb_alu, wb_rd} !== 73'b0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wb: got valid=%b ctrl=%b rdata=%h alu=%h rd=%0d stall=%b, required all 0",
                     wb_valid, wb_ctrl, wb_rdata, wb_alu, wb_rd, stall_o);
        end
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_alu();
        drive(5'b00001, 32'h0000_0010, 32'h0, 5'd7, 0, 32'h0);
        drive(5'b10011, 32'hFFFF_FFF0, 32'h0, 5'd31, 0, 32'h0);
        idle(1);
    endtask

    task automatic test_load();
        drive(5'b00111, 32'h0000_0100, 32'h0, 5'd9, 4, 32'hDEAD_BEEF);
        idle(1);
    endtask

    task automatic test_store();
        drive(5'b01000, 32'h0000_0204, 32'h1234_5678, 5'd3, 1, 32'h0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        drive(5'b00111, 32'h0000_0040, 32'h0, 5'd4, 2, 32'hCAFE_F00D);
        drive(5'b00001, 32'h0000_0055, 32'h0, 5'd12, 0, 32'h0);
        // MemRead and MemWrite both set: read wins
        drive(5'b01101, 32'h0000_0080, 32'hBAD0_BAD0, 5'd6, 3, 32'h0BAD_F00D);
        drive(5'b01000, 32'h0000_0088, 32'h5555_AAAA, 5'd0, 2, 32'h0);
        drive(5'b00011, 32'h0000_0099, 32'h0, 5'd1, 0, 32'h0);
        idle(2);
    endtask

    task automatic test_reset_mid_access();
        int w;
        @(negedge clk);
        mon_en   = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 5'b00111;
        in_alu   = 32'h0000_0300;
        in_rd    = 5'd2;
        w = 0;
        while (mem_req !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || w >= 10) begin
            n_fail++;
            $display("FAIL midreset_mem: got req=%b we=%b addr=%h wait=%0d, required 0 0 0", mem_req, mem_we, mem_addr, w);
        end
        n_checks++;
        if ({wb_valid, wb_ctrl, wb_rdata, wb_alu, wb_rd} !== 73'b0) begin
            n_fail++;
            $display("FAIL midreset_wb: got valid=%b ctrl=%b rdata=%h alu=%h rd=%0d, required all 0",
                     wb_valid, wb_ctrl, wb_rdata, wb_alu, wb_rd);
        end
        in_valid = 1'b0;
        in_ctrl  = 5'b0;
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || stall_o !== 1'b0 || wb_valid !== 1'b0 || wb_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL late_ack: got req=%b stall=%b wb_valid=%b rdata=%h, required 0 0 0 0",
                     mem_req, stall_o, wb_valid, wb_rdata);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_align();
        drive(5'b00111, 32'h0000_0103, 32'h0, 5'd11, 1, 32'hAAAA_5555);
        drive(5'b01001, 32'h0000_0202, 32'h7777_8888, 5'd13, 2, 32'h0);
        drive(5'b00001, 32'h0000_0021, 32'h0, 5'd14, 0, 32'h0);
        idle(2);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = 5'b0;
        in_alu    = 32'h0;
        in_wdata  = 32'h0;
        in_rd     = 5'd0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid_access();
        test_align();
        idle(2);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
